// File: rtl/class_argmax_pkg.sv
// Shared constants, types and the index-to-label map for the lenet classifier tail.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional: ARGMAX_MARGIN_EN enables second-best tracking in the users of this package.
package class_argmax_pkg;

    localparam int WD        = 15;
    localparam int N_CLASS   = 24;
    localparam int CLS_W     = 6;
    localparam int SKIP_LBL  = 9;
    localparam int MARGIN_TH = 16;

    typedef logic signed [WD:0]  score_t;
    typedef logic [CLS_W-1:0]    cls_t;
    typedef logic [WD+1:0]       margin_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam score_t SCORE_MIN = {1'b1, {WD{1'b0}}};

    // Sign-MNIST has no J, so every class at or above it shifts up by one.
    function automatic cls_t idx_to_label(input cls_t idx);
        if (idx < cls_t'(SKIP_LBL))
            return idx;
        else
            return idx + cls_t'(1);
    endfunction

endpackage

// File: rtl/class_argmax_if.sv
// Frame-control and score-stream bundle between lenet, class_argmax and text_lcd.
// Latency: n/a (wires only). Backpressure: none, the stream is push-only.
// Optional: ARGMAX_MARGIN_EN adds the margin/low_conf confidence signals.
interface class_argmax_if;
    import class_argmax_pkg::*;

    logic    go;
    logic    score_vld;
    score_t  score_data;
    logic    busy;
    cls_t    digit;
    logic    en_text_lcd;
    logic    ready;
`ifdef ARGMAX_MARGIN_EN
    margin_t margin;
    logic    low_conf;

    modport master (
        output go, score_vld, score_data,
        input  busy, digit, en_text_lcd, ready, margin, low_conf
    );
    modport slave (
        input  go, score_vld, score_data,
        output busy, digit, en_text_lcd, ready, margin, low_conf
    );
`else
    modport master (
        output go, score_vld, score_data,
        input  busy, digit, en_text_lcd, ready
    );
    modport slave (
        input  go, score_vld, score_data,
        output busy, digit, en_text_lcd, ready
    );
`endif

endinterface

// File: rtl/class_argmax_cmp.sv
// Compare-and-select of one (score, idx) beat against the running best (and second best).
// Latency: combinational. Backpressure: none.
// Optional: ARGMAX_MARGIN_EN adds the second-best update path.
module class_argmax_cmp
    import class_argmax_pkg::*;
(
    input  logic   first,
    input  score_t score,
    input  cls_t   idx,
    input  score_t best_val,
    input  cls_t   best_idx,
`ifdef ARGMAX_MARGIN_EN
    input  score_t second_val,
    output score_t second_nxt,
`endif
    output score_t best_val_nxt,
    output cls_t   best_idx_nxt
);

    logic win;

    // Strict compare so that an equal later score never displaces a lower index.
    assign win = first || (score > best_val);

    always_comb begin
        best_val_nxt = best_val;
        best_idx_nxt = best_idx;
        if (win) begin
            best_val_nxt = score;
            best_idx_nxt = idx;
        end
    end

`ifdef ARGMAX_MARGIN_EN
    always_comb begin
        second_nxt = second_val;
        if (win)
            second_nxt = best_val;
        else if (score > second_val)
            second_nxt = score;
    end
`endif

endmodule

// File: rtl/class_argmax.sv
// Argmax over one frame of N_CLASS signed scores, mapped to a Sign-MNIST label for text_lcd.
// Latency: ready/en_text_lcd one cycle after the final beat is sampled. Backpressure: none, beats always accepted in ACCUM.
// Optional: ARGMAX_MARGIN_EN adds registered margin/low_conf outputs.
module class_argmax
    import class_argmax_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    class_argmax_if.slave  bus
);

    state_t state, state_nxt;
    cls_t   cnt;
    score_t best_val, best_val_nxt;
    cls_t   best_idx, best_idx_nxt;
    cls_t   digit_q;
    logic   beat;
    logic   last;

    assign beat = (state == ACCUM) && bus.score_vld;
    assign last = beat && (cnt == cls_t'(N_CLASS - 1));

`ifdef ARGMAX_MARGIN_EN
    score_t  second_val, second_nxt;
    margin_t margin_nxt;
    margin_t margin_q;
    logic    low_conf_q;

    // Best never falls below second, so the widened difference is non-negative.
    assign margin_nxt = {best_val_nxt[WD], best_val_nxt} - {second_nxt[WD], second_nxt};
`endif

    class_argmax_cmp u_cmp (
        .first        (cnt == '0),
        .score        (bus.score_data),
        .idx          (cnt),
        .best_val     (best_val),
        .best_idx     (best_idx),
`ifdef ARGMAX_MARGIN_EN
        .second_val   (second_val),
        .second_nxt   (second_nxt),
`endif
        .best_val_nxt (best_val_nxt),
        .best_idx_nxt (best_idx_nxt)
    );

    always_ff @(posedge clk) begin
        if (rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.go) state_nxt = ACCUM;
            ACCUM:   if (last)   state_nxt = EMIT;
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt      <= '0;
            best_val <= SCORE_MIN;
            best_idx <= '0;
            digit_q  <= '0;
        end else if (state == IDLE && bus.go) begin
            cnt      <= '0;
            best_val <= SCORE_MIN;
            best_idx <= '0;
        end else if (beat) begin
            cnt      <= cnt + cls_t'(1);
            best_val <= best_val_nxt;
            best_idx <= best_idx_nxt;
            // Capture the label on the final beat so it is already valid during the strobe.
            if (last)
                digit_q <= idx_to_label(best_idx_nxt);
        end
    end

`ifdef ARGMAX_MARGIN_EN
    always_ff @(posedge clk) begin
        if (rstn) begin
            second_val <= SCORE_MIN;
            margin_q   <= '0;
            low_conf_q <= 1'b0;
        end else if (state == IDLE && bus.go) begin
            second_val <= SCORE_MIN;
        end else if (beat) begin
            second_val <= second_nxt;
            if (last) begin
                margin_q   <= margin_nxt;
                low_conf_q <= (margin_nxt < margin_t'(MARGIN_TH));
            end
        end
    end

    assign bus.margin   = margin_q;
    assign bus.low_conf = low_conf_q;
`endif

    assign bus.busy        = (state == ACCUM);
    assign bus.en_text_lcd = (state == EMIT);
    assign bus.ready       = (state == EMIT);
    assign bus.digit       = digit_q;

endmodule

// File: tb/tb_class_argmax.sv
// Directed frames through class_argmax with a queue of expected labels checked at each strobe.
// Latency: n/a (testbench). Backpressure: n/a, the stream is push-only.
module tb_class_argmax;
    import class_argmax_pkg::*;

    typedef struct {
        int digit;
        int margin;
        int low_conf;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic signed [15:0] sc [N_CLASS];

    class_argmax_if bus();

    class_argmax dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < N_CLASS; i++) sc[i] = 16'(v);
    endtask

    task automatic push_exp(input int d, input int m, input int lc);
        exp_t e;
        e.digit = d; e.margin = m; e.low_conf = lc;
        sb.push_back(e);
    endtask

    task automatic run_frame(input int gap_max, input bit go_mid, input bit go_at_emit);
        int   waited;
        int   ng;
        exp_t e;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        chk("busy_after_go", bus.busy, 1'b1);
        for (int i = 0; i < N_CLASS; i++) begin
            ng = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g < ng; g++) tick();
            if (ng > 0) chk("busy_in_gap", bus.busy, 1'b1);
            if (go_mid && i == 12) bus.go = 1'b1;
            bus.score_vld  = 1'b1;
            bus.score_data = sc[i];
            tick();
            bus.go        = 1'b0;
            bus.score_vld = 1'b0;
            if (i < N_CLASS - 1) begin
                if (i == 5 || i == 12 || i == 20) chk("no_early_strobe", bus.en_text_lcd, 1'b0);
            end
        end
        waited = 0;
        while (bus.en_text_lcd !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        chk("strobe_latency", waited, 0);
        chk("en_text_lcd_hi", bus.en_text_lcd, 1'b1);
        chk("ready_hi", bus.ready, 1'b1);
        chk("busy_in_emit", bus.busy, 1'b0);
        if (sb.size() == 0) begin
            e.digit = -1; e.margin = -1; e.low_conf = -1;
        end else begin
            e = sb.pop_front();
        end
        chk("digit", int'(bus.digit), e.digit);
        if (go_at_emit) bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        chk("en_text_lcd_one_cycle", bus.en_text_lcd, 1'b0);
        chk("ready_one_cycle", bus.ready, 1'b0);
        chk("busy_after_frame", bus.busy, 1'b0);
        chk("digit_held", int'(bus.digit), e.digit);
`ifdef ARGMAX_MARGIN_EN
        chk("margin", int'(bus.margin), e.margin);
        chk("low_conf", int'(bus.low_conf), e.low_conf);
`endif
    endtask

    initial begin
        int any_en;
        rstn           = 1'b1;
        bus.go         = 1'b0;
        bus.score_vld  = 1'b0;
        bus.score_data = '0;
        tick();
        tick();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_digit", int'(bus.digit), 0);
        chk("rst_en_text_lcd", bus.en_text_lcd, 1'b0);
        chk("rst_ready", bus.ready, 1'b0);
`ifdef ARGMAX_MARGIN_EN
        chk("rst_margin", int'(bus.margin), 0);
        chk("rst_low_conf", bus.low_conf, 1'b0);
`endif
        rstn = 1'b0;
        tick();

        for (int i = 0; i < N_CLASS; i++) sc[i] = 16'(i);
        push_exp(24, 1, 1);
        run_frame(0, 1'b0, 1'b1);

        fill(-5);
        sc[9] = 16'sd100;
        push_exp(10, 105, 0);
        run_frame(3, 1'b0, 1'b0);

        fill(-32768);
        sc[3] = 16'sh7FFF;
        sc[7] = 16'sh7FFF;
        push_exp(3, 0, 1);
        run_frame(1, 1'b1, 1'b0);

        bus.score_vld  = 1'b1;
        bus.score_data = 16'sd1000;
        tick();
        bus.score_vld  = 1'b0;
        chk("idle_beat_no_busy", bus.busy, 1'b0);
        fill(-32768);
        push_exp(0, 0, 1);
        run_frame(0, 1'b0, 1'b0);

        fill(500);
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.score_vld  = 1'b1;
            bus.score_data = sc[i];
            tick();
        end
        bus.score_vld = 1'b0;
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_digit", int'(bus.digit), 0);
        any_en = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.en_text_lcd === 1'b1 || bus.ready === 1'b1) any_en++;
        end
        chk("abort_no_strobe", any_en, 0);
        fill(-10);
        sc[8] = 16'sd42;
        push_exp(8, 52, 0);
        run_frame(2, 1'b0, 1'b0);

        fill(-100);
        sc[2] = 16'sd200;
        sc[5] = 16'sd190;
        push_exp(2, 10, 1);
        run_frame(0, 1'b0, 1'b0);
        sc[5] = 16'sd150;
        push_exp(2, 50, 0);
        run_frame(1, 1'b0, 1'b0);

        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
